// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the two buses the program loader sits between: the incoming
//   byte stream (valid/ready handshake) and the instruction-memory write
//   port that the loader drives.
//
//   master : the environment side. It sources bytes and observes/sinks the
//            memory write port.
//   slave  : the loader side. It sinks bytes and drives the memory writes.
//
//   Signals
//     byte_valid  stream byte is valid this cycle
//     byte_data   stream byte
//     byte_ready  loader accepts a byte this cycle
//     imem_we     instruction-memory write strobe
//     imem_addr   instruction-memory word address
//     imem_wdata  assembled 32-bit instruction word
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream program loader. It receives a frame of
//     N[7:0], N[15:8], N little-endian 32-bit words, XOR checksum byte
//   writes each assembled word into instruction memory at consecutive word
//   addresses starting at 0, and then releases the core via cpu_start if the
//   checksum matches. A bad checksum or an oversize header parks it in ERR.
//   load_req restarts loading from RUN or ERR.
//
//   Ports
//     clk, rst       system clock, synchronous active-high reset
//     load_req       one-cycle restart request (honoured in RUN/ERR only)
//     bus            byte stream in, instruction-memory write port out
//     cpu_start      level, core runs while high (RUN)
//     loading        high while a frame is being received
//     err            level, high in ERR
//     words_written  number of words written by the current load
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   HDR0  | waiting for word-count low byte
//   HDR1  | waiting for word-count high byte, range-check N
//   DATA  | assembling words, one memory write per 4 bytes
//   CHK   | waiting for checksum byte
//   RUN   | image accepted, core released
//   ERR   | oversize header or checksum mismatch, core held
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    imem_loader_if.slave     bus,
    output logic             cpu_start,
    output logic             loading,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        CHK,
        RUN,
        ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_words;
    logic [7:0]       csum;
    logic [1:0]       byte_idx;
    logic [23:0]      lanes;

    logic             xfer;
    logic [15:0]      hdr_n;
    logic [CNT_W-1:0] ww_next;

    assign xfer    = bus.byte_valid && bus.byte_ready;
    // Full header value as it will be once the high byte lands this cycle.
    assign hdr_n   = {bus.byte_data, n_words[7:0]};
    assign ww_next = words_written + CNT_W'(1);

    // Status outputs are pure decodes of the state register.
    assign bus.byte_ready = (state == HDR0) || (state == HDR1) ||
                            (state == DATA) || (state == CHK);
    assign loading        = bus.byte_ready;
    assign cpu_start      = (state == RUN);
    assign err            = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= HDR0;
            n_words        <= '0;
            csum           <= '0;
            byte_idx       <= '0;
            lanes          <= '0;
            words_written  <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                HDR0: begin
                    if (xfer) begin
                        n_words[7:0] <= bus.byte_data;
                        state        <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        n_words <= CNT_W'(hdr_n);
                        if (32'(hdr_n) > DEPTH)
                            state <= ERR;
                        else if (hdr_n == 16'd0)
                            state <= CHK;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ bus.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: lanes[7:0]   <= bus.byte_data;
                            2'd1: lanes[15:8]  <= bus.byte_data;
                            2'd2: lanes[23:16] <= bus.byte_data;
                            default: begin
                                // Fourth byte: the write is visible next
                                // cycle, together with the updated count.
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= words_written[ADDR_W-1:0];
                                bus.imem_wdata <= {bus.byte_data, lanes};
                                words_written  <= ww_next;
                                if (ww_next == n_words)
                                    state <= CHK;
                            end
                        endcase
                    end
                end
                CHK: begin
                    if (xfer)
                        state <= (bus.byte_data == csum) ? RUN : ERR;
                end
                RUN, ERR: begin
                    if (load_req) begin
                        state         <= HDR0;
                        n_words       <= '0;
                        csum          <= '0;
                        byte_idx      <= '0;
                        words_written <= '0;
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        cpu_start;
    logic        loading;
    logic        err;
    logic [15:0] words_written;

    imem_loader_if #(.ADDR_W(8)) bus();

    imem_loader #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .bus          (bus.slave),
        .cpu_start    (cpu_start),
        .loading      (loading),
        .err          (err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] fw [256];

    int          got_addr [$];
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    int          exp_cyc  [$];

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            got_addr.push_back(int'(bus.imem_addr));
            got_data.push_back(bus.imem_wdata);
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0, w1, w2;
        logic [7:0]  cdelta;
        int          gapmax;
        bit          exp_err;
        int          exp_ww;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rgap(input int gapmax);
        if (gapmax == 0) return 0;
        return int'($urandom_range(0, gapmax));
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int xc);
        int t;
        t = 0;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte_ready stayed %b for %0d cycles", bus.byte_ready, t);
            bus.byte_valid = 1'b0;
            xc = -1;
            return;
        end
        @(negedge clk);
        xc = cyc;
    endtask

    // Streams one frame built from fw[0..n-1]; the model expects those words
    // written at addresses 0..n-1 one cycle after their last byte, then the
    // given final status. Ends by pulsing load_req and checking the restart.
    task automatic run_frame(input logic [15:0] n, input logic [7:0] cdelta, input int gapmax,
                             input bit exp_err, input int exp_ww, input string tag);
        logic [7:0] x;
        int         xc;
        int         nexp;
        bit         over;
        over = (n > 16'd256);
        x    = 8'h00;
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        exp_cyc.delete();
        nexp = over ? 0 : int'(n);
        for (int i = 0; i < nexp; i++)
            x ^= fw[i][7:0] ^ fw[i][15:8] ^ fw[i][23:16] ^ fw[i][31:24];

        send_byte(n[7:0], rgap(gapmax), xc);
        send_byte(n[15:8], rgap(gapmax), xc);
        if (!over) begin
            for (int i = 0; i < nexp; i++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(fw[i][8*k +: 8], rgap(gapmax), xc);
                    if (k == 3) exp_cyc.push_back(xc);
                end
            end
            send_byte(x ^ cdelta, rgap(gapmax), xc);
        end
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);

        check($sformatf("%s_nwrites", tag), 64'(got_addr.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(i));
            check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(fw[i]));
            check($sformatf("%s_wcyc%0d", tag, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        check($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
        check($sformatf("%s_cpu_start", tag), 64'(cpu_start), 64'(!exp_err));
        check($sformatf("%s_words_written", tag), 64'(words_written), 64'(exp_ww));
        check($sformatf("%s_ready_final", tag), 64'(bus.byte_ready), 64'(0));
        check($sformatf("%s_loading_final", tag), 64'(loading), 64'(0));

        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check($sformatf("%s_reload_loading", tag), 64'(loading), 64'(1));
        check($sformatf("%s_reload_ready", tag), 64'(bus.byte_ready), 64'(1));
        check($sformatf("%s_reload_err", tag), 64'(err), 64'(0));
        check($sformatf("%s_reload_cpu_start", tag), 64'(cpu_start), 64'(0));
        check($sformatf("%s_reload_ww", tag), 64'(words_written), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'(1));
        check({tag, "_loading"}, 64'(loading), 64'(1));
        check({tag, "_we"}, 64'(bus.imem_we), 64'(0));
        check({tag, "_addr"}, 64'(bus.imem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'(0));
        check({tag, "_cpu_start"}, 64'(cpu_start), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_ww"}, 64'(words_written), 64'(0));
    endtask

    task automatic load_fw(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        fw[0] = w0;
        fw[1] = w1;
        fw[2] = w2;
        for (int i = 3; i < 256; i++) fw[i] = 32'(i) * 32'h9E3779B9 ^ 32'h5A5A0000;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int xc;
        logic [15:0] rn;
        logic [7:0]  rd;
        bit          rover;

        tbl[0] = '{16'd1,   32'h12345678, 32'h0, 32'h0, 8'h00, 0, 1'b0, 1};
        tbl[1] = '{16'd3,   32'hE3A00001, 32'hE2800002, 32'hEAFFFFFE, 8'h00, 0, 1'b0, 3};
        tbl[2] = '{16'd1,   32'h12345678, 32'h0, 32'h0, 8'h01, 0, 1'b1, 1};
        tbl[3] = '{16'h0101, 32'h0, 32'h0, 32'h0, 8'h00, 0, 1'b1, 0};
        tbl[4] = '{16'd0,   32'h0, 32'h0, 32'h0, 8'h00, 0, 1'b0, 0};
        tbl[5] = '{16'd0,   32'h0, 32'h0, 32'h0, 8'h05, 0, 1'b1, 0};
        tbl[6] = '{16'd3,   32'hE3A00001, 32'hE2800002, 32'hEAFFFFFE, 8'h00, 3, 1'b0, 3};
        tbl[7] = '{16'd256, 32'hCAFEF00D, 32'h0BADBEEF, 32'h00000000, 8'h00, 0, 1'b0, 256};
        tbl[8] = '{16'd2,   32'hFFFFFFFF, 32'h01020304, 32'h0, 8'h80, 1, 1'b1, 2};

        rst            = 1'b1;
        load_req       = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            load_fw(tbl[v].w0, tbl[v].w1, tbl[v].w2);
            run_frame(tbl[v].n, tbl[v].cdelta, tbl[v].gapmax, tbl[v].exp_err,
                      tbl[v].exp_ww, $sformatf("vec%0d", v));
        end

        // Reset in the middle of a word: partial data discarded.
        load_fw(32'hDEADBEEF, 32'h0, 32'h0);
        send_byte(8'h02, 0, xc);
        send_byte(8'h00, 0, xc);
        send_byte(8'h11, 0, xc);
        send_byte(8'h22, 0, xc);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        run_frame(16'd1, 8'h00, 0, 1'b0, 1, "after_rst");

        // Randomized frames against the model.
        for (int r = 0; r < 25; r++) begin
            rover = ($urandom_range(0, 9) == 0);
            rn    = rover ? 16'($urandom_range(257, 400)) : 16'($urandom_range(0, 12));
            for (int i = 0; i < 256; i++) fw[i] = $urandom;
            rd    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(rn, rd, int'($urandom_range(0, 3)), rover || (rd != 8'h00),
                      rover ? 0 : int'(rn), $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory before the single-cycle core fetches from it.
- The core is the memory reader; this block is the writer.
- Accepts a framed byte stream (header, little-endian 32-bit words, XOR checksum) over a valid/ready handshake.
- Issues one instruction-memory write per assembled word, then raises cpu_start so the PC begins fetching from address 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_req  input  1  one-cycle request to restart loading; honoured only in RUN or ERR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_start  output  1  level; core PC runs while high.
- loading  output  1  high in HDR0, HDR1, DATA, CHK.
- err  output  1  level; high in ERR.
- words_written  output  CNT_W  count of words written in the current load.

Behaviour:
- Byte transfer: a byte transfers in a cycle where byte_valid && byte_ready. byte_data is sampled only then.
- States: HDR0, HDR1, DATA, CHK, RUN, ERR.
- byte_ready is 1 in HDR0, HDR1, DATA and CHK; 0 in RUN and ERR.
- Reset: state=HDR0; byte_ready=1, loading=1; imem_we=0, imem_addr=0, imem_wdata=0, cpu_start=0, err=0, words_written=0. Internal checksum=0, byte index=0, N=0.
- Reset mid-load discards partial words and returns to HDR0. Memory contents already written are not cleared.
- HDR0: on transfer, N[7:0] ← byte; go to HDR1.
- HDR1: on transfer, N[15:8] ← byte. Then:
  - if N > DEPTH → ERR;
  - else if N == 0 → CHK;
  - else → DATA.
- Header bytes do not enter the checksum.
- DATA:
  - Each transfer places the byte into lane byte_index (0..3, little-endian: first byte → bits[7:0]) and XORs it into checksum.
  - On the 4th byte of a word, the next cycle has imem_we=1, imem_wdata = full word, imem_addr = words_written[ADDR_W-1:0]. words_written increments in that same cycle.
  - Write latency: exactly 1 cycle after the last byte of a word. imem_we is low in all other cycles.
  - Back-to-back bytes every cycle are supported; no bubbles are required.
  - When words_written reaches N (in the cycle of the final write), go to CHK.
  - byte_ready stays 1 during the write cycle.
- CHK: on transfer, compare the byte with checksum.
  - Equal → RUN.
  - Unequal → ERR.
- RUN: cpu_start=1, loading=0. Input bytes are ignored (byte_ready=0).
- ERR: err=1, cpu_start=0, loading=0.
- load_req in RUN or ERR:
  - next state HDR0; cpu_start and err drop on the next edge;
  - checksum, byte index and words_written clear to 0;
  - memory contents are untouched.
- load_req in any other state is ignored.
- If load_req coincides with rst, rst wins.
- Address wrap: impossible, since N ≤ DEPTH is enforced. N == DEPTH writes addresses 0..DEPTH-1.
- words_written holds its final value in RUN and ERR until the next load or reset.

Test Plan:
- Single word: stream 01 00 | 78 56 34 12 | 08 (checksum 78^56^34^12=08) → one imem_we pulse, addr 0, wdata 32'h12345678, one cycle after byte 0x12; then cpu_start=1, words_written=1, err=0.
- Three words sent with byte_valid held high continuously: header 03 00, words E3A00001, E2800002, EAFFFFFE, correct XOR checksum → writes at addr 0,1,2 with correct data; no dropped bytes; cpu_start=1.
- Bad checksum: same single-word frame with checksum 09 → no cpu_start; err=1; byte_ready=0. Then load_req pulse → HDR0, err=0, words_written=0, byte_ready=1.
- Oversize header: N=0x0101 with ADDR_W=8 → ERR right after the second header byte; no imem_we pulses.
- N=0: stream 00 00 00 → RUN with no writes. Same stream with checksum 05 → ERR.
- Gaps and reset: byte_valid toggled randomly during DATA → identical writes to the no-gap case. rst asserted after 2 data bytes → all outputs at reset values next cycle; a fresh full frame then loads correctly from addr 0.
